// File: rtl/iram_arbiter.sv
// Two-port arbiter in front of a single-port instruction RAM: fetch port A, loader/debug port B.
// Optional starvation guard for port B is enabled by defining IRAM_ARB_STARVE_GUARD_EN.
module iram_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              ram_rst,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    typedef enum logic {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tag_vld_q, tag_vld_d;
    logic              tag_b_q, tag_b_d;
    logic              force_b;

`ifdef IRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign force_b = (state_q == StArb) && b_req && (cnt_q == CntMax);

    always_comb begin
        cnt_d = '0;
        if (state_q == StArb && b_req && !b_gnt) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign force_b           = 1'b0;
`endif

    // Grants are held off for the whole cycle while reset is asserted.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        state_d = state_q;
        if (rst) begin
            unique case (state_q)
                StArb: begin
                    if (a_req && !force_b) begin
                        a_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end
                    if (b_gnt && b_lock) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    b_gnt = b_req;
                    if (!b_lock) begin
                        state_d = StArb;
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    always_comb begin
        addr_d    = addr_q;
        ram_wea   = 4'h0;
        ram_dina  = '0;
        if (a_gnt) begin
            addr_d = a_addr;
        end else if (b_gnt) begin
            addr_d   = b_addr;
            ram_wea  = b_we;
            ram_dina = b_wdata;
        end
        ram_addra = addr_d;
        tag_vld_d = a_gnt || (b_gnt && (b_we == 4'h0));
        tag_b_d   = b_gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StArb;
            addr_q    <= '0;
            tag_vld_q <= 1'b0;
            tag_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tag_vld_q <= tag_vld_d;
            tag_b_q   <= tag_b_d;
        end
    end

    assign a_rvalid = rst && tag_vld_q && !tag_b_q;
    assign b_rvalid = rst && tag_vld_q && tag_b_q;
    assign a_rdata  = ram_douta;
    assign b_rdata  = ram_douta;
    assign ram_rst  = ~rst;

endmodule

// File: tb/tb_iram_arbiter.sv
// Directed bench for iram_arbiter with a byte-writable synchronous RAM model on its RAM port.
module tb_iram_arbiter;

    localparam int unsigned ADDR_W = 12;

`ifdef IRAM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, b_req, b_lock;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [3:0]        b_we;
    logic [31:0]       b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid, ram_rst;
    logic [31:0]       a_rdata, b_rdata, ram_dina, ram_douta;
    logic [3:0]        ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    int n_asserts = 0;
    int n_fail    = 0;

    iram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_rst(ram_rst), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_douta(ram_douta)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with byte enables.
    always @(posedge clk) begin
        ram_douta <= mem[ram_addra];
        for (int k = 0; k < 4; k++) begin
            if (ram_wea[k]) mem[ram_addra][8*k +: 8] <= ram_dina[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA5A50000 | i;
        rst = 1'b0; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 4'h0;
        b_addr = '0; b_wdata = '0; b_lock = 1'b0;
        tick();
        tick();

        // Reset blocks everything
        a_req = 1'b1; a_addr = 12'd7; b_req = 1'b1; b_we = 4'hF;
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_wea", ram_wea, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_ram_rst", ram_rst, 1);
        check("rst_addr", ram_addra, 0);
        tick();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; b_we = 4'h0;
        #1;
        check("idle_ram_rst", ram_rst, 0);
        check("idle_addr", ram_addra, 0);
        check("idle_rvalid", a_rvalid, 0);

        // Three back-to-back A reads of address 5
        for (int i = 0; i < 3; i++) begin
            tick();
            a_req = 1'b1; a_addr = 12'd5;
            #1;
            check("a_rd_gnt", a_gnt, 1);
            check("a_rd_addr", ram_addra, 5);
            check("a_rd_wea", ram_wea, 0);
            if (i > 0) begin
                check("a_rd_rvalid", a_rvalid, 1);
                check("a_rd_data", a_rdata, 32'hA5A50005);
            end
        end
        tick();
        a_req = 1'b0;
        #1;
        check("a_rd_last_rvalid", a_rvalid, 1);
        check("a_rd_last_data", a_rdata, 32'hA5A50005);
        check("a_idle_gnt", a_gnt, 0);
        check("hold_addr", ram_addra, 5);
        tick();
        #1;
        check("a_rvalid_clear", a_rvalid, 0);

        // B full-word write then A read of same address
        b_req = 1'b1; b_we = 4'hF; b_addr = 12'd10; b_wdata = 32'hDEADBEEF;
        #1;
        check("b_wr_gnt", b_gnt, 1);
        check("b_wr_wea", ram_wea, 4'hF);
        check("b_wr_addr", ram_addra, 10);
        check("b_wr_dina", ram_dina, 32'hDEADBEEF);
        tick();
        b_req = 1'b0; b_we = 4'h0; a_req = 1'b1; a_addr = 12'd10;
        #1;
        check("wr_no_b_rvalid", b_rvalid, 0);
        check("raw_a_gnt", a_gnt, 1);
        tick();
        a_req = 1'b0;
        #1;
        check("raw_a_rvalid", a_rvalid, 1);
        check("raw_a_data", a_rdata, 32'hDEADBEEF);
        check("raw_no_b_rvalid", b_rvalid, 0);

        // Byte-lane write then B read back
        tick();
        b_req = 1'b1; b_we = 4'b0010; b_addr = 12'd20; b_wdata = 32'h12345678;
        #1;
        check("byte_wea", ram_wea, 4'b0010);
        check("byte_dina", ram_dina, 32'h12345678);
        tick();
        b_we = 4'h0;
        #1;
        check("b_rd_gnt", b_gnt, 1);
        check("b_rd_wea", ram_wea, 0);
        tick();
        b_req = 1'b0;
        #1;
        check("b_rd_rvalid", b_rvalid, 1);
        check("b_rd_a_rvalid", a_rvalid, 0);
        check("byte_data", b_rdata, 32'hA5A55614);

        // Contention: B forced only on the 9th cycle when the guard is built in
        for (int i = 1; i <= 12; i++) begin
            tick();
            a_req = 1'b1; a_addr = 12'd1; b_req = 1'b1; b_addr = 12'd2;
            #1;
            check($sformatf("starve_b_gnt_%0d", i), b_gnt, Guard && (i == 9));
            check($sformatf("starve_a_gnt_%0d", i), a_gnt, !(Guard && (i == 9)));
        end

        // Lock: B takes ownership, A stalls, released one cycle after b_lock drops
        tick();
        a_req = 1'b0; b_req = 1'b1; b_lock = 1'b1; b_addr = 12'd3;
        #1;
        check("lock_first_b_gnt", b_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            a_req = 1'b1;
            #1;
            check("locked_a_gnt", a_gnt, 0);
            check("locked_b_gnt", b_gnt, 1);
        end
        tick();
        b_lock = 1'b0;
        #1;
        check("unlock_cycle_a_gnt", a_gnt, 0);
        check("unlock_cycle_b_gnt", b_gnt, 1);
        tick();
        #1;
        check("after_unlock_a_gnt", a_gnt, 1);
        check("after_unlock_b_gnt", b_gnt, 0);

        // Reset right after a locked B read
        tick();
        a_req = 1'b0; b_req = 1'b1; b_lock = 1'b1; b_we = 4'h0; b_addr = 12'd20;
        #1;
        check("relock_b_gnt", b_gnt, 1);
        tick();
        a_req = 1'b1;
        #1;
        check("relock_a_gnt", a_gnt, 0);
        check("relock_b_rd", b_gnt, 1);
        tick();
        rst = 1'b0; b_we = 4'hF;
        #1;
        check("midlock_rst_b_rvalid", b_rvalid, 0);
        check("midlock_rst_b_gnt", b_gnt, 0);
        check("midlock_rst_a_gnt", a_gnt, 0);
        check("midlock_rst_wea", ram_wea, 0);
        tick();
        rst = 1'b1; b_we = 4'h0;
        #1;
        check("post_rst_a_gnt", a_gnt, 1);
        check("post_rst_b_gnt", b_gnt, 0);
        check("post_rst_b_rvalid", b_rvalid, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
